isp_decimate: RTL and testbench

ISP_DECIMATE -- requirements
Module: isp_decimate

---
 rtl/isp_decimate.sv | 173 +++++++++++++++++
 tb/tb_isp_decimate.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isp_decimate.sv
// -----------------------------------------------------------------------------
// isp_decimate
//   Pixel-stream decimator. Rows are kept when (row mod 2^shift_y) == 0.
//   Within a kept row, each channel is averaged over groups of 2^shift_x
//   consecutive pixels. With the latched enable at 0 every beat passes through
//   unchanged. Enable and shifts are sampled only on an accepted fstart beat,
//   so settings change only at frame boundaries.
//
// Handshake: an input beat is accepted when in_valid && out_ready. An output
//   beat is consumed when out_valid && in_ready. The output is a single
//   register; out_ready = in_ready || !out_valid, so upstream may push
//   whenever the register is empty or is being drained this cycle. While
//   out_valid=1 and in_ready=0, out_data/out_user are held.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   in_valid/in_data   upstream pixel (channel k at [k*COLOR_DEPTH +: COLOR_DEPTH])
//   in_user            [0]=hstart, [1]=fstart, [7:2] sideband
//   out_valid/out_data decimated pixel
//   out_user           [0]=first output of row, [1]=first output of frame,
//                      [7:2] from the last input of the group
//   in_ready           downstream ready
//   out_ready          ready to upstream
//   isp_ctrl           control word, bit EN_BIT enables decimation
//   shift_x, shift_y   log2 of horizontal / vertical decimation factors
// -----------------------------------------------------------------------------
module isp_decimate #(
    parameter int CHANNELS    = 3,
    parameter int COLOR_DEPTH = 8,
    parameter int EN_BIT      = 9
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [CHANNELS*COLOR_DEPTH-1:0] in_data,
    input  logic [7:0]                      in_user,
    output logic                            out_valid,
    output logic [CHANNELS*COLOR_DEPTH-1:0] out_data,
    output logic [7:0]                      out_user,
    input  logic                            in_ready,
    output logic                            out_ready,
    input  logic [15:0]                     isp_ctrl,
    input  logic [1:0]                      shift_x,
    input  logic [1:0]                      shift_y
);

    localparam int DW = CHANNELS * COLOR_DEPTH;
    localparam int AW = COLOR_DEPTH + 3;  // holds 8 full-scale samples

    localparam logic [0:0] WAIT_FRAME = 1'b0;
    localparam logic [0:0] RUN        = 1'b1;

    logic [0:0]                   state;
    logic                         en_q;
    logic [1:0]                   sx_q;
    logic [1:0]                   sy_q;
    logic [2:0]                   row_q;   // mod-8 is enough for factors up to 8
    logic [3:0]                   cnt_q;
    logic [CHANNELS-1:0][AW-1:0]  acc_q;
    logic                         row_first_q;
    logic                         frame_first_q;

    logic                         accept;
    logic                         fs;
    logic                         hs;
    logic                         first_px;
    logic                         live;
    logic                         en_e;
    logic [1:0]                   sx_e;
    logic [1:0]                   sy_e;
    logic [2:0]                   row_e;
    logic [2:0]                   ymask;
    logic                         kept;
    logic [3:0]                   cnt_next;
    logic                         group_done;
    logic                         rf_e;
    logic                         ff_e;
    logic                         emit;
    logic [CHANNELS-1:0][AW-1:0]  acc_sum;
    logic [DW-1:0]                dec_data;

    // Only EN_BIT of the control word is used.
    logic unused_ctrl;
    assign unused_ctrl = ^isp_ctrl;

    assign out_ready = in_ready || !out_valid;

    always_comb begin
        accept   = in_valid && out_ready;
        fs       = in_user[1];
        hs       = in_user[0];
        first_px = fs || hs;
        // An fstart beat is processed even from WAIT_FRAME.
        live     = accept && (state == RUN || fs);
        // The fstart beat itself already uses the settings it carries.
        en_e     = fs ? isp_ctrl[EN_BIT] : en_q;
        sx_e     = fs ? shift_x : sx_q;
        sy_e     = fs ? shift_y : sy_q;
        row_e    = fs ? 3'd0 : (hs ? row_q + 3'd1 : row_q);
        ymask    = 3'((4'd1 << sy_e) - 4'd1);
        kept     = (row_e & ymask) == 3'd0;
        // hstart/fstart start a fresh group: any partial group is dropped.
        cnt_next   = (first_px ? 4'd0 : cnt_q) + 4'd1;
        group_done = cnt_next == (4'd1 << sx_e);
        rf_e       = first_px || row_first_q;
        ff_e       = fs || frame_first_q;
        acc_sum    = '0;
        dec_data   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            acc_sum[k] = (first_px ? AW'(0) : acc_q[k])
                       + AW'(in_data[k*COLOR_DEPTH +: COLOR_DEPTH]);
            dec_data[k*COLOR_DEPTH +: COLOR_DEPTH] = COLOR_DEPTH'(acc_sum[k] >> sx_e);
        end
        emit = live && (!en_e || (kept && group_done));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_FRAME;
            en_q          <= 1'b0;
            sx_q          <= 2'd0;
            sy_q          <= 2'd0;
            row_q         <= 3'd0;
            cnt_q         <= 4'd0;
            acc_q         <= '0;
            row_first_q   <= 1'b0;
            frame_first_q <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_user      <= 8'd0;
        end else begin
            // emit implies accept, which implies the register is free.
            if (emit) begin
                out_valid <= 1'b1;
            end else if (in_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && fs) begin
                state <= RUN;
                en_q  <= isp_ctrl[EN_BIT];
                sx_q  <= shift_x;
                sy_q  <= shift_y;
            end

            if (live) begin
                row_q         <= row_e;
                row_first_q   <= rf_e;
                frame_first_q <= ff_e;
                if (!en_e) begin
                    out_data <= in_data;
                    out_user <= in_user;
                    acc_q    <= '0;
                    cnt_q    <= 4'd0;
                end else if (kept && group_done) begin
                    out_data      <= dec_data;
                    out_user      <= {in_user[7:2], ff_e, rf_e};
                    row_first_q   <= 1'b0;
                    frame_first_q <= 1'b0;
                    acc_q         <= '0;
                    cnt_q         <= 4'd0;
                end else if (kept) begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_next;
                end else begin
                    acc_q <= '0;
                    cnt_q <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_isp_decimate.sv
module tb_isp_decimate;
    localparam int CH     = 3;
    localparam int CD     = 8;
    localparam int DW     = CH * CD;
    localparam int EN_BIT = 9;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [7:0]    in_user;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [7:0]    out_user;
    logic          in_ready;
    logic          out_ready;
    logic [15:0]   isp_ctrl;
    logic [1:0]    shift_x;
    logic [1:0]    shift_y;

    isp_decimate #(.CHANNELS(CH), .COLOR_DEPTH(CD), .EN_BIT(EN_BIT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_user(in_user),
        .out_valid(out_valid), .out_data(out_data), .out_user(out_user),
        .in_ready(in_ready), .out_ready(out_ready),
        .isp_ctrl(isp_ctrl), .shift_x(shift_x), .shift_y(shift_y)
    );

    int errors = 0;
    int checks = 0;

    // scoreboard: {user, data}
    logic [DW+7:0] exp_q[$];
    logic [DW+7:0] got_q[$];

    // current frame
    logic [DW-1:0] f_pix[$];
    logic [7:0]    f_user[$];
    int            f_w, f_h, f_sx, f_sy;
    bit            f_en;
    bit            rand_ready = 1'b0;

    // in_ready only changes 2 time units after a rising edge.
    always @(posedge clk) begin
        #2;
        if (rand_ready) in_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (!reset && out_valid && in_ready) got_q.push_back({out_user, out_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] pix_val(int mode, int r, int c);
        logic [DW-1:0] v;
        v = DW'($urandom);
        if (mode == 1) begin
            for (int k = 0; k < CH; k++) v[k*CD +: CD] = CD'(10 * r + c + k);
        end else if (mode == 2 && c < 4) begin
            v = '1;
        end
        return v;
    endfunction

    // Build a frame and append its expected outputs (frame-level arithmetic).
    task automatic prep_frame(int w, int h, bit en, int sx, int sy, int mode);
        int fx, fy, last, sum;
        bit first;
        logic [DW-1:0] d;
        f_w = w; f_h = h; f_en = en; f_sx = sx; f_sy = sy;
        f_pix.delete();
        f_user.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                f_pix.push_back(pix_val(mode, r, c));
                f_user.push_back({6'($urandom), 1'(r == 0 && c == 0), 1'(c == 0)});
            end
        end
        if (!en) begin
            for (int i = 0; i < w * h; i++) exp_q.push_back({f_user[i], f_pix[i]});
        end else begin
            fx = 1 << sx;
            fy = 1 << sy;
            first = 1'b1;
            for (int r = 0; r < h; r += fy) begin
                for (int g = 0; g < w / fx; g++) begin
                    for (int k = 0; k < CH; k++) begin
                        sum = 0;
                        for (int j = 0; j < fx; j++) sum += int'(f_pix[r*w + g*fx + j][k*CD +: CD]);
                        d[k*CD +: CD] = CD'(sum / fx);
                    end
                    last = r * w + g * fx + fx - 1;
                    exp_q.push_back({f_user[last][7:2], first, 1'(g == 0), d});
                    first = 1'b0;
                end
            end
        end
    endtask

    // driver tasks (called at a falling edge, return at a falling edge)
    task automatic set_ready(logic v);
        @(posedge clk);
        #2;
        in_ready = v;
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [7:0] u);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_user  = u;
        while (!out_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout got out_ready=0 for %0d cycles, need 1", n);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(bit gaps, bit scr, int nsx, int nsy);
        for (int i = 0; i < f_pix.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            if (i == 0) begin
                isp_ctrl = 16'($urandom);
                isp_ctrl[EN_BIT] = f_en;
                shift_x = 2'(f_sx);
                shift_y = 2'(f_sy);
            end else if (i == 1 && scr) begin
                isp_ctrl[EN_BIT] = ~f_en;
                shift_x = 2'(nsx);
                shift_y = 2'(nsy);
            end
            send_beat(f_pix[i], f_user[i]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (got_q.size() < exp_q.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_user = 8'd0;
        in_ready = 1'b0; isp_ctrl = 16'd0; shift_x = 2'd0; shift_y = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_user !== 8'd0) begin errors++; $display("FAIL reset_out_user got=%h exp=0", out_user); end
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_out_ready got=%b exp=1", out_ready); end
        // Before any fstart, everything is discarded even in bypass.
        set_ready(1'b1);
        for (int i = 0; i < 3; i++) send_beat(DW'($urandom), 8'(i == 0));
        repeat (4) @(negedge clk);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL wait_frame_discard got=%0d outputs exp=0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] d;
        logic [7:0] u;
        isp_ctrl = 16'd0; shift_x = 2'd3; shift_y = 2'd3;
        for (int i = 0; i < 8; i++) begin
            d = {3{8'(i + 1)}};
            u = {6'(i), 1'(i == 0), 1'(i % 4 == 0)};
            in_valid = 1'b1; in_data = d; in_user = u;
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid beat %0d got=%b exp=1", i, out_valid); end
            checks++;
            if ({out_user, out_data} !== {u, d}) begin
                errors++; $display("FAIL bypass_data beat %0d got=%h exp=%h", i, {out_user, out_data}, {u, d});
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bypass_valid_clear got=%b exp=0", out_valid); end
        got_q.delete();
    endtask

    task automatic test_decim_2x2();
        logic [7:0] want[4];
        logic [1:0] want_u[4];
        want   = '{8'd0, 8'd2, 8'd20, 8'd22};
        want_u = '{2'b11, 2'b00, 2'b01, 2'b00};
        prep_frame(4, 4, 1'b1, 1, 1, 1);
        send_frame(1'b0, 1'b0, 0, 0);
        drain();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_q.size()) begin
                errors++; $display("FAIL d2x2_missing output %0d got=none exp=%0d", i, want[i]);
            end else if (got_q[i][7:0] !== want[i] || got_q[i][DW+1:DW] !== want_u[i]) begin
                errors++; $display("FAIL d2x2_value output %0d got=%0d/%b exp=%0d/%b",
                                   i, got_q[i][7:0], got_q[i][DW+1:DW], want[i], want_u[i]);
            end
        end
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL d2x2_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL d2x2_model %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        set_ready(1'b0);
        prep_frame(8, 1, 1'b1, 2, 0, 2);
        fork
            send_frame(1'b0, 1'b0, 0, 0);
            begin
                int n;
                n = 0;
                while (!out_valid && n < 50) begin @(negedge clk); n++; end
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || out_ready !== 1'b0 || out_data !== {DW{1'b1}}) begin
                        errors++; $display("FAIL bp_hold cycle %0d got v=%b r=%b d=%h exp v=1 r=0 d=%h",
                                           i, out_valid, out_ready, out_data, {DW{1'b1}});
                    end
                end
                @(posedge clk);
                #2 in_ready = 1'b1;
            end
        join
        drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_model %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_ragged();
        set_ready(1'b1);
        prep_frame(10, 3, 1'b1, 3, 0, 0);
        send_frame(1'b1, 1'b0, 0, 0);
        drain();
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL ragged_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ragged_model %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_midframe_change();
        set_ready(1'b1);
        // Settings (including enable) change after the fstart beat.
        prep_frame(8, 4, 1'b1, 1, 0, 0);
        send_frame(1'b0, 1'b1, 2, 1);
        drain();
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL mid_old_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_old_model %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
        prep_frame(8, 4, 1'b1, 2, 1, 0);
        send_frame(1'b0, 1'b0, 0, 0);
        drain();
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL mid_new_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_new_model %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe();
        set_ready(1'b0);
        prep_frame(8, 2, 1'b1, 0, 0, 0);
        exp_q.delete();
        isp_ctrl = 16'd0; isp_ctrl[EN_BIT] = 1'b1; shift_x = 2'd0; shift_y = 2'd0;
        send_beat(f_pix[0], f_user[0]);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pending got=%b exp=1", out_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
        checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", out_ready); end
        set_ready(1'b1);
        for (int i = 1; i < 5; i++) send_beat(f_pix[i], f_user[i]);
        repeat (4) @(negedge clk);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_mid_silent got=%0d outputs exp=0", got_q.size()); end
        got_q.delete();
        prep_frame(6, 2, 1'b1, 1, 0, 0);
        send_frame(1'b0, 1'b0, 0, 0);
        drain();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_mid_model %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            prep_frame($urandom_range(1, 12), $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), $urandom_range(0, 3), 0);
            send_frame(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        drain();
        rand_ready = 1'b0;
        set_ready(1'b1);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_model %0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_decim_2x2();
        test_backpressure();
        test_ragged();
        test_midframe_change();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
